// File: rtl/chad_io_bridge.sv
// Bridges the chad core's single-cycle I/O strobes to a req/ack peripheral bus,
// stalling the core via cpu_hold until the peripheral acks or the access times out.
module chad_io_bridge #(
  parameter int WIDTH   = 18,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [14:0]      io_addr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_din,
  output logic             cpu_hold,
  output logic             p_req,
  output logic             p_we,
  output logic [14:0]      p_addr,
  output logic [WIDTH-1:0] p_wdata,
  input  logic [WIDTH-1:0] p_rdata,
  input  logic             p_ack,
  output logic             err,
  input  logic             err_clr
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             p_we_q, p_we_d;
  logic [14:0]      p_addr_q, p_addr_d;
  logic [WIDTH-1:0] p_wdata_q, p_wdata_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             strobe;
  logic             timeout;

  assign strobe  = io_rd | io_wr;
  assign timeout = (state_q == REQ) && !p_ack && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d   = state_q;
    p_we_d    = p_we_q;
    p_addr_d  = p_addr_q;
    p_wdata_d = p_wdata_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    cpu_hold  = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by resetq so the core is released the instant reset asserts.
        cpu_hold = resetq & strobe;
        if (strobe) begin
          p_addr_d  = io_addr;
          p_wdata_d = io_wdata;
          p_we_d    = io_wr;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        cpu_hold = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (p_ack) begin
          if (!p_we_q) data_d = p_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '1;
          state_d = DONE;
        end
      end
      // The strobe still visible here belongs to the finished instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (err_clr)      err_d = 1'b0;
    else if (timeout) err_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= IDLE;
      p_we_q    <= 1'b0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      p_we_q    <= p_we_d;
      p_addr_q  <= p_addr_d;
      p_wdata_q <= p_wdata_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign p_req   = (state_q == REQ);
  assign p_we    = p_we_q;
  assign p_addr  = p_addr_q;
  assign p_wdata = p_wdata_q;
  assign io_din  = data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_chad_io_bridge.sv
// Directed bench for chad_io_bridge: a small model pushes expected completions
// to a scoreboard queue, popped and compared when each access reaches DONE.
module tb_chad_io_bridge;

  localparam int W   = 18;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          resetq;
  logic          io_rd, io_wr;
  logic [14:0]   io_addr;
  logic [W-1:0]  io_wdata;
  logic [W-1:0]  io_din;
  logic          cpu_hold;
  logic          p_req, p_we;
  logic [14:0]   p_addr;
  logic [W-1:0]  p_wdata;
  logic [W-1:0]  p_rdata;
  logic          p_ack;
  logic          err;
  logic          err_clr;

  chad_io_bridge #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_din   (io_din),
    .cpu_hold (cpu_hold),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_ack    (p_ack),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] din;
    int           req_cycles;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_din;
  logic         model_err;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge that starts the cycle after
  // DONE, with the strobes still driven (as a stalled core would leave them).
  task automatic do_access(input logic rd, input logic wr, input logic [14:0] addr,
                           input logic [W-1:0] wdata, input logic [W-1:0] rdata,
                           input int ack_at);
    exp_t e;
    exp_t got;
    int   n_req  = 0;
    int   n_hold = 0;
    bit   done   = 0;
    if (ack_at >= 1 && ack_at <= TMO) begin
      e.req_cycles = ack_at;
      if (!wr) model_din = rdata;
    end else begin
      e.req_cycles = TMO;
      model_din    = '1;
      model_err    = 1'b1;
    end
    e.din = model_din;
    e.err = model_err;
    sb.push_back(e);

    io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = wdata;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (cpu_hold) n_hold++;
      if (p_req) begin
        n_req++;
        check("p_addr_stable", p_addr, addr);
        check("p_wdata_stable", p_wdata, wdata);
        check("p_we", p_we, wr);
        io_addr  = ~addr;
        io_wdata = ~wdata;
        p_ack    = (n_req == ack_at);
        p_rdata  = p_ack ? rdata : ~rdata;
      end else begin
        p_ack = 1'b0;
        if (n_req > 0) begin
          done = 1;
          got  = sb.pop_front();
          check("done_hold_low", cpu_hold, 0);
          check("io_din", io_din, got.din);
          check("err", err, got.err);
          check("req_cycles", n_req, got.req_cycles);
          check("hold_cycles", n_hold, got.req_cycles + 1);
        end
      end
      @(negedge clk);
    end
    if (!done) check("access_completes", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    io_rd = 1'b0; io_wr = 1'b0;
    repeat (n) begin
      #1;
      check("idle_p_req", p_req, 0);
      check("idle_hold", cpu_hold, 0);
      check("idle_err", err, model_err);
      check("idle_io_din", io_din, model_din);
      @(negedge clk);
    end
  endtask

  initial begin
    resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    p_rdata = '0; p_ack = 1'b0; err_clr = 1'b0;
    model_din = '0; model_err = 1'b0;

    #2;
    check("rst_p_req", p_req, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_io_din", io_din, 0);
    check("rst_err", err, 0);
    check("rst_p_addr", p_addr, 0);
    check("rst_p_wdata", p_wdata, 0);
    check("rst_p_we", p_we, 0);
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
    idle_cycles(2);

    // Read acked on the first REQ cycle.
    do_access(1'b1, 1'b0, 15'h0007, 18'h00000, 18'h2A5A5, 1);
    idle_cycles(2);
    // Write acked on the sixth REQ cycle; io_din must keep the read data.
    do_access(1'b0, 1'b1, 15'h0012, 18'h01234, 18'h11111, 6);
    idle_cycles(2);
    // Both strobes: treated as a write.
    do_access(1'b1, 1'b1, 15'h7FFF, 18'h3C3C3, 18'h22222, 2);
    idle_cycles(1);
    // Ack on the timeout cycle: data captured, err stays clear.
    do_access(1'b1, 1'b0, 15'h0100, 18'h00000, 18'h0BEEF, TMO);
    idle_cycles(1);
    // Back-to-back read then write, strobes held through DONE.
    do_access(1'b1, 1'b0, 15'h0021, 18'h00000, 18'h1ABCD, 3);
    do_access(1'b0, 1'b1, 15'h0022, 18'h05555, 18'h00000, 1);
    idle_cycles(4);
    // Read with no ack: timeout, all-ones data, sticky err.
    do_access(1'b1, 1'b0, 15'h0033, 18'h00000, 18'h01111, 0);
    idle_cycles(3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    model_err = 1'b0;
    #1 check("err_cleared", err, 0);
    @(negedge clk);
    idle_cycles(1);

    // Set err again, then reset in the middle of an access.
    do_access(1'b1, 1'b0, 15'h0044, 18'h00000, 18'h01111, 0);
    io_rd = 1'b1; io_wr = 1'b0; io_addr = 15'h0055;
    repeat (3) @(negedge clk);
    #1 check("pre_reset_p_req", p_req, 1);
    #1 resetq = 1'b0;
    #1;
    check("mid_rst_p_req", p_req, 0);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_io_din", io_din, 0);
    model_din = '0;
    model_err = 1'b0;
    @(negedge clk);
    io_rd  = 1'b0;
    resetq = 1'b1;
    p_ack  = 1'b1;
    p_rdata = 18'h3ABCD;
    #1 check("late_ack_p_req", p_req, 0);
    @(negedge clk);
    p_ack = 1'b0;
    idle_cycles(3);

    // Bridge still works after reset.
    do_access(1'b1, 1'b0, 15'h0066, 18'h00000, 18'h00F0F, 4);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
